// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects, load-use hazard detection and mul/div busy
// interlock, with a saturating count of stalled cycles.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W      = 5,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int MULDIV_CYCLES   = 4,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_instr_rs,
  input  logic [REG_ADDR_W-1:0] id_instr_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_muldiv,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_write_reg_addr,
  input  logic [REG_ADDR_W-1:0] id_ex_instr_rs,
  input  logic [REG_ADDR_W-1:0] id_ex_instr_rt,
  input  logic                  ex_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_mem_write_reg_addr,
  input  logic                  mem_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_write_reg_addr,
  input  logic                  flush,
  output logic [1:0]            Forward_A,
  output logic [1:0]            Forward_B,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_flush,
  output logic                  muldiv_busy,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_LU_STALL = 2'd1;
  localparam logic [1:0] S_MULDIV   = 2'd2;

  localparam int LU_INIT = (LOAD_USE_CYCLES > 1) ? LOAD_USE_CYCLES - 2 : 0;
  localparam int MD_INIT = (MULDIV_CYCLES > 1) ? MULDIV_CYCLES - 1 : 0;
  localparam int CMAX    = (LU_INIT > MD_INIT) ? LU_INIT : MD_INIT;
  localparam int CW      = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

  logic [1:0]       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_ex_hit_a, w_ex_hit_b, w_wb_hit_a, w_wb_hit_b;
  logic             w_lu_haz, w_stall;

  assign w_ex_hit_a = ex_mem_reg_write && (ex_mem_write_reg_addr != '0)
                      && (ex_mem_write_reg_addr == id_ex_instr_rs);
  assign w_ex_hit_b = ex_mem_reg_write && (ex_mem_write_reg_addr != '0)
                      && (ex_mem_write_reg_addr == id_ex_instr_rt);
  assign w_wb_hit_a = mem_wb_reg_write && (mem_wb_write_reg_addr != '0)
                      && (mem_wb_write_reg_addr == id_ex_instr_rs);
  assign w_wb_hit_b = mem_wb_reg_write && (mem_wb_write_reg_addr != '0)
                      && (mem_wb_write_reg_addr == id_ex_instr_rt);

  always_comb begin
    Forward_A = 2'b00;
    Forward_B = 2'b00;
    if (w_ex_hit_a)      Forward_A = 2'b10;
    else if (w_wb_hit_a) Forward_A = 2'b01;
    if (w_ex_hit_b)      Forward_B = 2'b10;
    else if (w_wb_hit_b) Forward_B = 2'b01;
  end

  assign w_lu_haz = id_ex_mem_read && (id_ex_write_reg_addr != '0)
                    && ((id_ex_write_reg_addr == id_instr_rs)
                        || (id_uses_rt && (id_ex_write_reg_addr == id_instr_rt)));

  assign w_stall = ((r_state == S_RUN) && w_lu_haz && !flush)
                   || (r_state == S_LU_STALL) || (r_state == S_MULDIV);

  assign pc_write    = !w_stall;
  assign if_id_write = !w_stall;
  assign id_ex_flush = w_stall || flush;
  assign muldiv_busy = (r_state == S_MULDIV);
  assign stall_count = r_stall_count;

  // The RUN cycle that detects a load-use already stalls, so LU_STALL only
  // covers the remaining LOAD_USE_CYCLES-1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_lu_haz) begin
            if (LOAD_USE_CYCLES > 1) begin
              w_state_nxt = S_LU_STALL;
              w_cnt_nxt   = CW'(LU_INIT);
            end
          end else if (id_muldiv) begin
            w_state_nxt = S_MULDIV;
            w_cnt_nxt   = CW'(MD_INIT);
          end
        end
        S_LU_STALL, S_MULDIV: begin
          if (r_cnt == '0) w_state_nxt = S_RUN;
          else             w_cnt_nxt   = r_cnt - CW'(1);
        end
        default: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_cnt         <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_stall && (r_stall_count != '1))
        r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding priority, load-use and mul/div
// stalls, flush, asynchronous reset and counter saturation (CNT_W=3).
module tb_fwd_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] id_instr_rs, id_instr_rt;
  logic       id_uses_rt, id_muldiv, id_ex_mem_read;
  logic [4:0] id_ex_write_reg_addr, id_ex_instr_rs, id_ex_instr_rt;
  logic       ex_mem_reg_write, mem_wb_reg_write;
  logic [4:0] ex_mem_write_reg_addr, mem_wb_write_reg_addr;
  logic       flush;
  logic [1:0] Forward_A, Forward_B;
  logic       pc_write, if_id_write, id_ex_flush, muldiv_busy;
  logic [2:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  fwd_hazard_unit #(
    .REG_ADDR_W(5),
    .LOAD_USE_CYCLES(2),
    .MULDIV_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_instr_rs(id_instr_rs),
    .id_instr_rt(id_instr_rt),
    .id_uses_rt(id_uses_rt),
    .id_muldiv(id_muldiv),
    .id_ex_mem_read(id_ex_mem_read),
    .id_ex_write_reg_addr(id_ex_write_reg_addr),
    .id_ex_instr_rs(id_ex_instr_rs),
    .id_ex_instr_rt(id_ex_instr_rt),
    .ex_mem_reg_write(ex_mem_reg_write),
    .ex_mem_write_reg_addr(ex_mem_write_reg_addr),
    .mem_wb_reg_write(mem_wb_reg_write),
    .mem_wb_write_reg_addr(mem_wb_write_reg_addr),
    .flush(flush),
    .Forward_A(Forward_A),
    .Forward_B(Forward_B),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .id_ex_flush(id_ex_flush),
    .muldiv_busy(muldiv_busy),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 ns after the rising edge; checks follow 1 ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    id_instr_rs = '0; id_instr_rt = '0; id_uses_rt = 1'b0; id_muldiv = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_write_reg_addr = '0;
    id_ex_instr_rs = '0; id_ex_instr_rt = '0;
    ex_mem_reg_write = 1'b0; ex_mem_write_reg_addr = '0;
    mem_wb_reg_write = 1'b0; mem_wb_write_reg_addr = '0;
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    chk("rst_pc_write", 16'(pc_write), 16'd1);
    chk("rst_if_id_write", 16'(if_id_write), 16'd1);
    chk("rst_id_ex_flush", 16'(id_ex_flush), 16'd0);
    chk("rst_busy", 16'(muldiv_busy), 16'd0);
    chk("rst_count", 16'(stall_count), 16'd0);
    reset = 1'b0;

    // Forwarding priority and independence
    ex_mem_reg_write = 1'b1; ex_mem_write_reg_addr = 5'd5;
    mem_wb_reg_write = 1'b1; mem_wb_write_reg_addr = 5'd5;
    id_ex_instr_rs = 5'd5; id_ex_instr_rt = 5'd5;
    #1;
    chk("fwd_both_A", 16'(Forward_A), 16'd2);
    chk("fwd_both_B", 16'(Forward_B), 16'd2);
    ex_mem_reg_write = 1'b0;
    #1;
    chk("fwd_wb_A", 16'(Forward_A), 16'd1);
    chk("fwd_wb_B", 16'(Forward_B), 16'd1);
    ex_mem_reg_write = 1'b1;
    ex_mem_write_reg_addr = 5'd0; mem_wb_write_reg_addr = 5'd0;
    id_ex_instr_rs = 5'd0; id_ex_instr_rt = 5'd0;
    #1;
    chk("fwd_r0_A", 16'(Forward_A), 16'd0);
    chk("fwd_r0_B", 16'(Forward_B), 16'd0);
    ex_mem_write_reg_addr = 5'd3; id_ex_instr_rs = 5'd3;
    mem_wb_write_reg_addr = 5'd7; id_ex_instr_rt = 5'd7;
    #1;
    chk("fwd_ind_A", 16'(Forward_A), 16'd2);
    chk("fwd_ind_B", 16'(Forward_B), 16'd1);
    idle();

    // Load-use on rs: two stall cycles
    tick();
    id_ex_mem_read = 1'b1; id_ex_write_reg_addr = 5'd4; id_instr_rs = 5'd4;
    #1;
    chk("lu1_pc_write", 16'(pc_write), 16'd0);
    chk("lu1_if_id_write", 16'(if_id_write), 16'd0);
    chk("lu1_id_ex_flush", 16'(id_ex_flush), 16'd1);
    tick();
    id_ex_mem_read = 1'b0; id_ex_write_reg_addr = '0;
    #1;
    chk("lu2_pc_write", 16'(pc_write), 16'd0);
    chk("lu2_id_ex_flush", 16'(id_ex_flush), 16'd1);
    chk("lu2_count", 16'(stall_count), 16'd1);
    tick();
    #1;
    chk("lu_end_pc_write", 16'(pc_write), 16'd1);
    chk("lu_end_id_ex_flush", 16'(id_ex_flush), 16'd0);
    chk("lu_end_count", 16'(stall_count), 16'd2);
    // rt match ignored when rt unused; r0 destination never hazards
    id_ex_mem_read = 1'b1; id_ex_write_reg_addr = 5'd4;
    id_instr_rs = 5'd0; id_instr_rt = 5'd4; id_uses_rt = 1'b0;
    #1;
    chk("lu_rt_unused", 16'(pc_write), 16'd1);
    id_uses_rt = 1'b1;
    #1;
    chk("lu_rt_used", 16'(pc_write), 16'd0);
    id_ex_write_reg_addr = 5'd0; id_instr_rt = 5'd0;
    #1;
    chk("lu_r0", 16'(pc_write), 16'd1);
    idle();

    // Reset clears the counter, then mul/div interlock
    tick();
    reset = 1'b1;
    #1;
    chk("rst2_count", 16'(stall_count), 16'd0);
    reset = 1'b0;
    tick();
    id_muldiv = 1'b1;
    #1;
    chk("md_issue_pc_write", 16'(pc_write), 16'd1);
    chk("md_issue_busy", 16'(muldiv_busy), 16'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      id_muldiv = 1'b0;
      #1;
      chk($sformatf("md_c%0d_busy", i + 1), 16'(muldiv_busy), 16'd1);
      chk($sformatf("md_c%0d_pc_write", i + 1), 16'(pc_write), 16'd0);
    end
    tick();
    #1;
    chk("md_end_busy", 16'(muldiv_busy), 16'd0);
    chk("md_end_pc_write", 16'(pc_write), 16'd1);
    chk("md_end_count", 16'(stall_count), 16'd4);

    // Load-use and mul/div together: load-use first, then the held mul/div
    id_ex_mem_read = 1'b1; id_ex_write_reg_addr = 5'd4; id_instr_rs = 5'd4;
    id_muldiv = 1'b1;
    #1;
    chk("sim_lu1_pc_write", 16'(pc_write), 16'd0);
    chk("sim_lu1_busy", 16'(muldiv_busy), 16'd0);
    tick();
    id_ex_mem_read = 1'b0; id_ex_write_reg_addr = '0;
    #1;
    chk("sim_lu2_pc_write", 16'(pc_write), 16'd0);
    chk("sim_lu2_busy", 16'(muldiv_busy), 16'd0);
    tick();
    #1;
    chk("sim_issue_pc_write", 16'(pc_write), 16'd1);
    chk("sim_issue_busy", 16'(muldiv_busy), 16'd0);
    chk("sim_issue_count", 16'(stall_count), 16'd6);
    tick();
    id_muldiv = 1'b0;
    #1;
    chk("sim_md1_busy", 16'(muldiv_busy), 16'd1);
    tick();
    flush = 1'b1;
    #1;
    chk("flush_md2_busy", 16'(muldiv_busy), 16'd1);
    chk("flush_md2_pc_write", 16'(pc_write), 16'd0);
    chk("flush_md2_id_ex_flush", 16'(id_ex_flush), 16'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_run_pc_write", 16'(pc_write), 16'd1);
    chk("flush_run_busy", 16'(muldiv_busy), 16'd0);
    chk("flush_sat_count", 16'(stall_count), 16'd7);

    // Asynchronous reset in the middle of a mul/div
    id_muldiv = 1'b1;
    tick();
    id_muldiv = 1'b0;
    tick();
    #1;
    chk("pre_rst_busy", 16'(muldiv_busy), 16'd1);
    chk("pre_rst_count_sat", 16'(stall_count), 16'd7);
    reset = 1'b1;
    #1;
    chk("arst_busy", 16'(muldiv_busy), 16'd0);
    chk("arst_pc_write", 16'(pc_write), 16'd1);
    chk("arst_if_id_write", 16'(if_id_write), 16'd1);
    chk("arst_id_ex_flush", 16'(id_ex_flush), 16'd0);
    chk("arst_count", 16'(stall_count), 16'd0);
    reset = 1'b0;

    // Nine stalled cycles saturate a 3-bit counter at 7
    id_ex_mem_read = 1'b1; id_ex_write_reg_addr = 5'd9; id_instr_rs = 5'd9;
    for (int i = 0; i < 9; i++) tick();
    #1;
    chk("sat9_count", 16'(stall_count), 16'd7);
    idle();
    tick();
    tick();
    #1;
    chk("sat_hold_count", 16'(stall_count), 16'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
